// File: rtl/regfile_write_sequencer.sv
// Serialises up to two write-back register writes per cycle onto the single
// register-file write port, in program order, with a bypass lookup for decode.
module regfile_write_sequencer #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in1_valid,
    input  logic [REG_W-1:0]  in1_reg,
    input  logic [DATA_W-1:0] in1_value,
    input  logic              in2_valid,
    input  logic [REG_W-1:0]  in2_reg,
    input  logic [DATA_W-1:0] in2_value,
    output logic              in_ready,
    input  logic              rf_ready,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_reg,
    output logic [DATA_W-1:0] rf_value,
    input  logic [REG_W-1:0]  q_reg,
    output logic              q_hit,
    output logic [DATA_W-1:0] q_value,
    output logic              idle,
    output logic              err_overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [REG_W-1:0] NULL_REG = {REG_W{1'b1}};

    logic [REG_W-1:0]  entry_reg   [DEPTH];
    logic [DATA_W-1:0] entry_value [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             eff1;
    logic             eff2;
    logic             push1;
    logic             push2;
    logic             pop;
    logic [1:0]       push_cnt;
    logic [PTR_W-1:0] slot2;
    logic [CNT_W-1:0] count_next;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                input logic [1:0]       inc);
        ptr_add = ptr + PTR_W'(inc);
    endfunction

    // Request qualification: the null id never occupies an entry
    always_comb begin
        eff1     = in1_valid && (in1_reg != NULL_REG);
        eff2     = in2_valid && (in2_reg != NULL_REG);
        in_ready = (count <= CNT_W'(DEPTH - 2));
        push1    = eff1 && in_ready;
        push2    = eff2 && in_ready;
        push_cnt = {1'b0, push1} + {1'b0, push2};
        slot2    = push1 ? ptr_add(wr_ptr, 2'd1) : wr_ptr;
        rf_we    = (count != '0);
        pop      = rf_we && rf_ready;
        idle     = (count == '0);
        count_next = count + CNT_W'(push_cnt) - CNT_W'(pop);
    end

    // Control state; entry storage below is deliberately left unreset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
        end else begin
            wr_ptr <= ptr_add(wr_ptr, push_cnt);
            if (pop) begin
                rd_ptr <= ptr_add(rd_ptr, 2'd1);
            end
            count <= count_next;
            if (!in_ready && (eff1 || eff2)) begin
                err_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push1) begin
            entry_reg[wr_ptr]   <= in1_reg;
            entry_value[wr_ptr] <= in1_value;
        end
        if (push2) begin
            entry_reg[slot2]   <= in2_reg;
            entry_value[slot2] <= in2_value;
        end
    end

    always_comb begin
        rf_reg   = entry_reg[rd_ptr];
        rf_value = entry_value[rd_ptr];
    end

    // Walk oldest to youngest so the last match wins, i.e. the youngest entry
    always_comb begin
        q_hit   = 1'b0;
        q_value = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (q_reg != NULL_REG) &&
                (entry_reg[rd_ptr + PTR_W'(i)] == q_reg)) begin
                q_hit   = 1'b1;
                q_value = entry_value[rd_ptr + PTR_W'(i)];
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed bench for regfile_write_sequencer: ordering, null ids, overflow,
// pointer wrap, bypass lookup and asynchronous reset.
module tb_regfile_write_sequencer;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;
    localparam int DEPTH  = 4;

    logic              clock;
    logic              reset_n;
    logic              in1_valid;
    logic [REG_W-1:0]  in1_reg;
    logic [DATA_W-1:0] in1_value;
    logic              in2_valid;
    logic [REG_W-1:0]  in2_reg;
    logic [DATA_W-1:0] in2_value;
    logic              in_ready;
    logic              rf_ready;
    logic              rf_we;
    logic [REG_W-1:0]  rf_reg;
    logic [DATA_W-1:0] rf_value;
    logic [REG_W-1:0]  q_reg;
    logic              q_hit;
    logic [DATA_W-1:0] q_value;
    logic              idle;
    logic              err_overflow;

    int tests;
    int fails;

    regfile_write_sequencer #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .in1_valid(in1_valid), .in1_reg(in1_reg), .in1_value(in1_value),
        .in2_valid(in2_valid), .in2_reg(in2_reg), .in2_value(in2_value),
        .in_ready(in_ready), .rf_ready(rf_ready), .rf_we(rf_we),
        .rf_reg(rf_reg), .rf_value(rf_value), .q_reg(q_reg),
        .q_hit(q_hit), .q_value(q_value), .idle(idle),
        .err_overflow(err_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        in1_valid = 1'b0; in1_reg = 4'hF; in1_value = '0;
        in2_valid = 1'b0; in2_reg = 4'hF; in2_value = '0;
    endtask

    task automatic set_pair(input logic v1, input logic [3:0] r1, input logic [31:0] d1,
                            input logic v2, input logic [3:0] r2, input logic [31:0] d2);
        in1_valid = v1; in1_reg = r1; in1_value = d1;
        in2_valid = v2; in2_reg = r2; in2_value = d2;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rf_ready = 1'b0; q_reg = 4'd3;
        clear_inputs();
        #2;
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL reset_rf_we: got %b expected 0", rf_we); end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle: got %b expected 1", idle); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests++; if (err_overflow !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err_overflow); end
        tests++; if (q_hit !== 1'b0) begin fails++; $display("FAIL reset_q_hit: got %b expected 0", q_hit); end
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_dual_push();
        rf_ready = 1'b1;
        set_pair(1'b1, 4'd3, 32'h11, 1'b1, 4'd6, 32'h22);
        tick();
        clear_inputs(); #1;
        tests++; if (rf_we !== 1'b1 || rf_reg !== 4'd3 || rf_value !== 32'h11)
            begin fails++; $display("FAIL dual_first: got we=%b reg=%0h val=%0h expected 1/3/11", rf_we, rf_reg, rf_value); end
        tick();
        tests++; if (rf_we !== 1'b1 || rf_reg !== 4'd6 || rf_value !== 32'h22)
            begin fails++; $display("FAIL dual_second: got we=%b reg=%0h val=%0h expected 1/6/22", rf_we, rf_reg, rf_value); end
        tick();
        tests++; if (rf_we !== 1'b0 || idle !== 1'b1)
            begin fails++; $display("FAIL dual_idle: got we=%b idle=%b expected 0/1", rf_we, idle); end
    endtask

    task automatic test_same_reg();
        rf_ready = 1'b0;
        set_pair(1'b1, 4'd6, 32'hA, 1'b1, 4'd6, 32'hB);
        tick();
        clear_inputs(); q_reg = 4'd6; #1;
        tests++; if (q_hit !== 1'b1 || q_value !== 32'hB)
            begin fails++; $display("FAIL same_lookup: got hit=%b val=%0h expected 1/b", q_hit, q_value); end
        tick();
        tests++; if (rf_we !== 1'b1 || rf_value !== 32'hA)
            begin fails++; $display("FAIL same_hold: got we=%b val=%0h expected 1/a", rf_we, rf_value); end
        rf_ready = 1'b1;
        tick();
        tests++; if (rf_we !== 1'b1 || rf_reg !== 4'd6 || rf_value !== 32'hB)
            begin fails++; $display("FAIL same_second: got we=%b reg=%0h val=%0h expected 1/6/b", rf_we, rf_reg, rf_value); end
        tests++; if (q_hit !== 1'b1 || q_value !== 32'hB)
            begin fails++; $display("FAIL same_lookup2: got hit=%b val=%0h expected 1/b", q_hit, q_value); end
        tick();
        tests++; if (idle !== 1'b1 || q_hit !== 1'b0 || q_value !== 32'h0)
            begin fails++; $display("FAIL same_miss: got idle=%b hit=%b val=%0h expected 1/0/0", idle, q_hit, q_value); end
    endtask

    task automatic test_null_ids();
        rf_ready = 1'b0;
        set_pair(1'b1, 4'hF, 32'hDEAD, 1'b1, 4'd2, 32'h5);
        tick();
        clear_inputs(); q_reg = 4'hF; #1;
        tests++; if (rf_we !== 1'b1 || rf_reg !== 4'd2 || rf_value !== 32'h5)
            begin fails++; $display("FAIL null_one: got we=%b reg=%0h val=%0h expected 1/2/5", rf_we, rf_reg, rf_value); end
        tests++; if (q_hit !== 1'b0)
            begin fails++; $display("FAIL null_lookup: got hit=%b expected 0", q_hit); end
        rf_ready = 1'b1;
        tick();
        tests++; if (idle !== 1'b1)
            begin fails++; $display("FAIL null_single_entry: got idle=%b expected 1", idle); end
        rf_ready = 1'b0;
        set_pair(1'b1, 4'hF, 32'h1, 1'b1, 4'hF, 32'h2);
        tick();
        clear_inputs(); #1;
        tests++; if (rf_we !== 1'b0 || idle !== 1'b1)
            begin fails++; $display("FAIL null_both: got we=%b idle=%b expected 0/1", rf_we, idle); end
    endtask

    task automatic test_overflow();
        rf_ready = 1'b0;
        set_pair(1'b1, 4'd1, 32'h101, 1'b1, 4'd2, 32'h102);
        tick();
        clear_inputs(); #1;
        tests++; if (in_ready !== 1'b1)
            begin fails++; $display("FAIL ovf_ready2: got %b expected 1", in_ready); end
        set_pair(1'b1, 4'd3, 32'h103, 1'b1, 4'd4, 32'h104);
        tick();
        clear_inputs(); #1;
        tests++; if (in_ready !== 1'b0 || err_overflow !== 1'b0)
            begin fails++; $display("FAIL ovf_full: got ready=%b err=%b expected 0/0", in_ready, err_overflow); end
        set_pair(1'b1, 4'd5, 32'h105, 1'b1, 4'd7, 32'h107);
        tick();
        clear_inputs(); q_reg = 4'd5; #1;
        tests++; if (err_overflow !== 1'b1)
            begin fails++; $display("FAIL ovf_err: got %b expected 1", err_overflow); end
        tests++; if (q_hit !== 1'b0)
            begin fails++; $display("FAIL ovf_dropped_lookup: got hit=%b expected 0", q_hit); end
        q_reg = 4'd4; #1;
        tests++; if (q_hit !== 1'b1 || q_value !== 32'h104)
            begin fails++; $display("FAIL ovf_lookup_tail: got hit=%b val=%0h expected 1/104", q_hit, q_value); end
        rf_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (rf_we !== 1'b1 || rf_reg !== 4'(k + 1) || rf_value !== 32'(32'h101 + k))
                begin fails++; $display("FAIL ovf_drain%0d: got we=%b reg=%0h val=%0h expected 1/%0h/%0h",
                                        k, rf_we, rf_reg, rf_value, k + 1, 32'h101 + k); end
            tick();
        end
        tests++; if (idle !== 1'b1 || in_ready !== 1'b1 || err_overflow !== 1'b1)
            begin fails++; $display("FAIL ovf_after: got idle=%b ready=%b err=%b expected 1/1/1", idle, in_ready, err_overflow); end
    endtask

    task automatic test_wrap();
        rf_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            set_pair(1'b1, 4'd5, 32'(32'h200 + c), 1'b0, 4'hF, 32'h0);
            tick();
            tests++;
            if (rf_we !== 1'b1 || rf_value !== 32'(32'h200 + c) || in_ready !== 1'b1)
                begin fails++; $display("FAIL wrap%0d: got we=%b val=%0h ready=%b expected 1/%0h/1",
                                        c, rf_we, rf_value, in_ready, 32'h200 + c); end
        end
        clear_inputs();
        tick();
        tests++; if (idle !== 1'b1)
            begin fails++; $display("FAIL wrap_idle: got %b expected 1", idle); end
    endtask

    task automatic test_reset_mid();
        rf_ready = 1'b0;
        set_pair(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hA2);
        tick();
        set_pair(1'b1, 4'd3, 32'hA3, 1'b0, 4'hF, 32'h0);
        tick();
        clear_inputs(); #1;
        tests++; if (rf_we !== 1'b1 || in_ready !== 1'b0)
            begin fails++; $display("FAIL rstmid_pre: got we=%b ready=%b expected 1/0", rf_we, in_ready); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if (rf_we !== 1'b0 || idle !== 1'b1 || in_ready !== 1'b1 || err_overflow !== 1'b0)
            begin fails++; $display("FAIL rstmid_async: got we=%b idle=%b ready=%b err=%b expected 0/1/1/0",
                                    rf_we, idle, in_ready, err_overflow); end
        tick();
        reset_n = 1'b1;
        rf_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (rf_we !== 1'b0)
                begin fails++; $display("FAIL rstmid_quiet%0d: got we=%b expected 0", k, rf_we); end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_dual_push();
        test_same_reg();
        test_null_ids();
        test_overflow();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_write_sequencer.md
Name: regfile_write_sequencer

Overview:
Sits between the write-back stage and the register file. Write-back produces up to two register writes per cycle, for example popl/ret-style updates of %esp plus rA. The register file has one write port. This block queues both writes in program order, drains them one per cycle through a ready/write handshake, and exposes a lookup port so decode can bypass values that are still pending.

Parameters:
DATA_W, 32, register value width
REG_W, 4, register id width; id 'hF means "no register"
DEPTH, 4, queue entries; power of 2, >= 2

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in1_valid  input  1  write request 1 (older)
in1_reg  input  REG_W  destination of request 1
in1_value  input  DATA_W  data of request 1
in2_valid  input  1  write request 2 (younger)
in2_reg  input  REG_W  destination of request 2
in2_value  input  DATA_W  data of request 2
in_ready  output  1  high when at least 2 entries are free
rf_ready  input  1  register file accepts a write this cycle
rf_we  output  1  head entry valid (queue not empty)
rf_reg  output  REG_W  head entry register id
rf_value  output  DATA_W  head entry value
q_reg  input  REG_W  lookup register id
q_hit  output  1  a queued entry targets q_reg
q_value  output  DATA_W  value of the youngest queued entry targeting q_reg
idle  output  1  queue empty
err_overflow  output  1  sticky: a request arrived while in_ready was low

Behaviour:
- Storage: circular buffer of DEPTH {reg, value} entries, with rd_ptr, wr_ptr and a count sized to hold 0..DEPTH.
- Reset (async, reset_n=0): rd_ptr=wr_ptr=count=0 and err_overflow=0. This gives rf_we=0, idle=1, in_ready=1 and q_hit=0. Entry contents are don't-care.
- Reset in the middle of a drain discards all pending writes. No partial write is issued after reset deasserts.
- in_ready = (count <= DEPTH-2), evaluated combinationally from the registered count. It does not depend on a pop in the same cycle.
- Filtering: a request counts as effective when inN_valid=1 and inN_reg != 'hF. Requests with reg 'hF are dropped silently and consume no entry.
- Push when in_ready=1, at the rising edge:
  - Effective req1 is written to wr_ptr.
  - Effective req2 is written to the next slot: wr_ptr+1 if req1 was effective, else wr_ptr.
  - wr_ptr advances by the number of effective requests (0, 1 or 2), modulo DEPTH.
- Overflow: any effective request while in_ready=0 is dropped and sets err_overflow=1. It stays set until reset.
- Drain: rf_we=(count!=0); rf_reg and rf_value come from entry[rd_ptr].
  - The write completes on an edge where rf_we=1 and rf_ready=1. At that edge rd_ptr advances by 1.
  - If rf_ready=0, the head and its outputs hold stable.
- Count update: count_next = count + pushes - pop. Push and pop in the same cycle are legal. A pop from an empty queue is impossible because it is gated by rf_we.
- Write latency: a request accepted at edge N appears on rf_* in cycle N+1 at the earliest, when the queue was empty.
- Ordering:
  - Strict FIFO.
  - When both requests target the same register, req1 is written first and req2 second, so req2's value is final.
  - No merging of entries.
- Lookup (combinational):
  - Scan valid entries from youngest to oldest and return the first entry whose reg == q_reg.
  - q_reg='hF always gives q_hit=0.
  - Requests arriving in the current cycle are not visible until the following cycle.
  - On a miss, q_value=0.
- Pointer wrap: pointers wrap modulo DEPTH. Full (count=DEPTH) and empty (count=0) are distinguished by count only.

Test Plan:
- Reset: hold reset_n=0 mid-cycle with 3 entries queued -> immediately rf_we=0, idle=1, in_ready=1, err_overflow=0. After release, no rf_we pulse until a new push.
- Dual push, rf_ready=1: in1={3,'h11}, in2={6,'h22} in one cycle -> rf_we high for 2 cycles, with {3,'h11} first and then {6,'h22}. idle returns to 1 after that.
- Same-register order: in1={6,'hA}, in2={6,'hB}, rf_ready=0 -> q_reg=6 gives q_hit=1, q_value='hB. Raising rf_ready writes 'hA, then 'hB.
- Null ids: in1={'hF,x}, in2={2,'h5} -> exactly one entry, {2,'h5}. in1 and in2 both 'hF -> no entry and no rf_we.
- Backpressure/overflow with DEPTH=4, rf_ready=0: push 2 pairs -> count=4, in_ready=0. A third pair is dropped and err_overflow=1 stays set. The 4 original entries then drain in order once rf_ready=1.
- Wrap plus concurrent push/pop: rf_ready=1 and continuous single pushes of incrementing values over 10 cycles -> count stays at 1. rf_value sequence equals the input sequence across pointer wrap, and in_ready stays high throughout.
